// File: rtl/mem_pkg.sv
// Shared constants, request bundle and address helper for the dual-port RAM.
package mem_pkg;

  localparam int unsigned MEM_DEPTH  = 16;
  localparam int unsigned MEM_DWIDTH = 8;
  localparam int unsigned MEM_AWIDTH = $clog2(MEM_DEPTH);

  // One port request: enable plus address.
  typedef struct packed {
    logic                  en;
    logic [MEM_AWIDTH-1:0] addr;
  } mem_req_t;

  // True when addr selects a real entry of a depth-entry array.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_wr_tracker.sv
// Tracks which entries have been written since reset and how many distinct ones.
module mem_wr_tracker
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = MEM_DEPTH,
  parameter int unsigned AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit,
  input  logic [AWIDTH-1:0] addr,
  input  logic [AWIDTH-1:0] query_addr,
  output logic              is_written,
  output logic [AWIDTH:0]   occupancy
);

  // Flag vector covers the full address space so any query indexes legally;
  // flags at or above DEPTH are never set.
  localparam int unsigned NFLAGS = 1 << AWIDTH;
  localparam int unsigned CWIDTH = AWIDTH + 1;

  logic [NFLAGS-1:0] written;
  logic              accept;

  assign accept = commit && addr_in_range(32'(addr), DEPTH);

  // Set the flag on commit; count only first-time writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written   <= '0;
      occupancy <= '0;
    end else if (accept) begin
      written[addr] <= 1'b1;
      if (!written[addr]) begin
        occupancy <= occupancy + CWIDTH'(1);
      end
    end
  end

  assign is_written = written[query_addr];

endmodule

// File: rtl/mem_dp_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port with valid.
module mem_dp_ram
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = MEM_DEPTH,
  parameter int unsigned DWIDTH = MEM_DWIDTH,
  parameter int unsigned AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_enbl,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_enbl,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_uninit,
  output logic              addr_err,
  output logic [AWIDTH:0]   occupancy
);

  logic [DWIDTH-1:0] mem [DEPTH];

  logic wr_ok;
  logic rd_ok;
  logic wr_commit;
  logic rd_take;
  logic collide;
  logic rd_written;

  assign wr_ok     = addr_in_range(32'(wr_addr), DEPTH);
  assign rd_ok     = addr_in_range(32'(rd_addr), DEPTH);
  assign wr_commit = wr_enbl && wr_ok;
  assign rd_take   = rd_enbl && rd_ok;
  assign collide   = wr_commit && rd_take && (wr_addr == rd_addr);

  mem_wr_tracker #(
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .commit     (wr_commit),
    .addr       (wr_addr),
    .query_addr (rd_addr),
    .is_written (rd_written),
    .occupancy  (occupancy)
  );

  // Array write; contents are not reset, and reset blocks any commit.
  always_ff @(posedge clk) begin
    if (!rst && wr_commit) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register: write-first bypass, zero for never-written entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_uninit <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      addr_err <= (wr_enbl && !wr_ok) || (rd_enbl && !rd_ok);
      if (rd_take) begin
        rd_valid <= 1'b1;
        if (collide) begin
          rd_data   <= wr_data;
          rd_uninit <= 1'b0;
        end else if (!rd_written) begin
          rd_data   <= '0;
          rd_uninit <= 1'b1;
        end else begin
          rd_data   <= mem[rd_addr];
          rd_uninit <= 1'b0;
        end
      end else begin
        rd_valid  <= 1'b0;
        rd_uninit <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_dp_ram.sv
// Bench for mem_dp_ram: a 16-deep and a 10-deep instance share one stimulus
// stream and are checked every cycle against an array-based reference model.
module tb_mem_dp_ram;
  import mem_pkg::*;

  localparam int unsigned AW = MEM_AWIDTH;
  localparam int unsigned DW = MEM_DWIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_enbl = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_enbl = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic [DW-1:0] rd_data   [2];
  logic          rd_valid  [2];
  logic          rd_uninit [2];
  logic          addr_err  [2];
  logic [AW:0]   occupancy [2];

  always #5 clk = ~clk;

  mem_dp_ram #(.DEPTH(16), .DWIDTH(DW), .AWIDTH(AW)) dut16 (
    .clk(clk), .rst(rst),
    .wr_enbl(wr_enbl), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_enbl(rd_enbl), .rd_addr(rd_addr),
    .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .rd_uninit(rd_uninit[0]),
    .addr_err(addr_err[0]), .occupancy(occupancy[0])
  );

  mem_dp_ram #(.DEPTH(10), .DWIDTH(DW), .AWIDTH(AW)) dut10 (
    .clk(clk), .rst(rst),
    .wr_enbl(wr_enbl), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_enbl(rd_enbl), .rd_addr(rd_addr),
    .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .rd_uninit(rd_uninit[1]),
    .addr_err(addr_err[1]), .occupancy(occupancy[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays and the behavioural rules.
  int            depth_of [2] = '{16, 10};
  logic [DW-1:0] m_mem [2][16];
  bit            m_wr  [2][16];
  int            m_occ [2];
  logic [DW-1:0] e_data  [2];
  bit            e_valid [2];
  bit            e_un    [2];
  bit            e_err   [2];
  int            wa, ra, dep;

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) m_wr[d][i] = 1'b0;
        m_occ[d] = 0; e_data[d] = '0; e_valid[d] = 0; e_un[d] = 0; e_err[d] = 0;
      end else begin
        wa  = int'(wr_addr);
        ra  = int'(rd_addr);
        dep = depth_of[d];
        e_err[d] = (wr_enbl && wa >= dep) || (rd_enbl && ra >= dep);
        if (rd_enbl && ra < dep) begin
          e_valid[d] = 1;
          if (wr_enbl && wa == ra) begin
            e_data[d] = wr_data; e_un[d] = 0;
          end else if (!m_wr[d][ra]) begin
            e_data[d] = '0; e_un[d] = 1;
          end else begin
            e_data[d] = m_mem[d][ra]; e_un[d] = 0;
          end
        end else begin
          e_valid[d] = 0; e_un[d] = 0;
        end
        if (wr_enbl && wa < dep) begin
          if (!m_wr[d][wa]) m_occ[d]++;
          m_wr[d][wa]  = 1'b1;
          m_mem[d][wa] = wr_data;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("m%0d.rd_data", d),   32'(rd_data[d]),   32'(e_data[d]));
      chk($sformatf("m%0d.rd_valid", d),  32'(rd_valid[d]),  32'(e_valid[d]));
      chk($sformatf("m%0d.rd_uninit", d), 32'(rd_uninit[d]), 32'(e_un[d]));
      chk($sformatf("m%0d.addr_err", d),  32'(addr_err[d]),  32'(e_err[d]));
      chk($sformatf("m%0d.occupancy", d), 32'(occupancy[d]), 32'(m_occ[d]));
    end
  end

  function automatic mem_req_t mk(input logic en, input int addr);
    mem_req_t r;
    r.en   = en;
    r.addr = AW'(addr);
    return r;
  endfunction

  // Apply one cycle of requests; returns 2 time units after the clock edge.
  task automatic step(input mem_req_t w, input logic [DW-1:0] wd, input mem_req_t r);
    wr_enbl = w.en; wr_addr = w.addr; wr_data = wd;
    rd_enbl = r.en; rd_addr = r.addr;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    wr_enbl = 1'b0; rd_enbl = 1'b0;
  endtask

  mem_req_t      none;
  logic [DW-1:0] fill_val;

  initial begin
    none = mk(1'b0, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Uninitialised read after reset.
    step(none, 8'h00, mk(1'b1, 3));
    chk("uninit_valid", 32'(rd_valid[0]), 32'd1);
    chk("uninit_flag",  32'(rd_uninit[0]), 32'd1);
    chk("uninit_data",  32'(rd_data[0]), 32'h00);
    chk("uninit_occ",   32'(occupancy[0]), 32'd0);

    // Write then read back.
    step(mk(1'b1, 2), 8'hA5, none);
    step(none, 8'h00, mk(1'b1, 2));
    chk("rb_data",  32'(rd_data[0]), 32'hA5);
    chk("rb_valid", 32'(rd_valid[0]), 32'd1);
    chk("rb_uninit", 32'(rd_uninit[0]), 32'd0);
    chk("rb_occ",   32'(occupancy[0]), 32'd1);

    // Same-address collision, then rewrite.
    step(mk(1'b1, 5), 8'h3C, mk(1'b1, 5));
    chk("coll_data",   32'(rd_data[0]), 32'h3C);
    chk("coll_uninit", 32'(rd_uninit[0]), 32'd0);
    chk("coll_occ",    32'(occupancy[0]), 32'd2);
    step(mk(1'b1, 5), 8'h11, none);
    chk("rewr_occ",   32'(occupancy[0]), 32'd2);
    chk("rewr_valid", 32'(rd_valid[0]), 32'd0);
    chk("rewr_hold",  32'(rd_data[0]), 32'h3C);

    // Fill every address, then read all back to back.
    for (int i = 0; i < 16; i++) begin
      fill_val = DW'(i * 17 + 3);
      step(mk(1'b1, i), fill_val, none);
    end
    chk("fill_occ16", 32'(occupancy[0]), 32'd16);
    chk("fill_occ10", 32'(occupancy[1]), 32'd10);
    for (int i = 0; i < 16; i++) begin
      fill_val = DW'(i * 17 + 3);
      step(none, 8'h00, mk(1'b1, i));
      chk($sformatf("b2b_valid%0d", i), 32'(rd_valid[0]), 32'd1);
      chk($sformatf("b2b_data%0d", i),  32'(rd_data[0]), 32'(fill_val));
    end

    // Out-of-range on both ports of the 10-deep instance.
    step(mk(1'b1, 12), 8'h77, mk(1'b1, 11));
    chk("oor_err10",   32'(addr_err[1]), 32'd1);
    chk("oor_valid10", 32'(rd_valid[1]), 32'd0);
    chk("oor_occ10",   32'(occupancy[1]), 32'd10);
    chk("oor_err16",   32'(addr_err[0]), 32'd0);
    step(none, 8'h00, none);
    chk("oor_pulse10", 32'(addr_err[1]), 32'd0);

    // Asynchronous reset between edges with a read pending.
    step(none, 8'h00, mk(1'b1, 2));
    chk("pre_rst_valid", 32'(rd_valid[0]), 32'd1);
    rd_addr = AW'(4);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(rd_valid[0]), 32'd0);
    chk("arst_occ",   32'(occupancy[0]), 32'd0);
    chk("arst_occ10", 32'(occupancy[1]), 32'd0);
    idle_inputs();
    @(posedge clk);
    #2 rst = 1'b0;
    step(none, 8'h00, mk(1'b1, 2));
    chk("post_rst_uninit", 32'(rd_uninit[0]), 32'd1);
    chk("post_rst_valid",  32'(rd_valid[0]), 32'd1);
    chk("post_rst_data",   32'(rd_data[0]), 32'h00);

    // Randomized traffic with biased collisions and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      int ra_r;
      int wa_r;
      wa_r = int'($urandom_range(0, 15));
      ra_r = ($urandom_range(0, 3) == 0) ? wa_r : int'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        idle_inputs();
        #1 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
      end else begin
        step(mk(1'($urandom_range(0, 1)), wa_r), DW'($urandom),
             mk(1'($urandom_range(0, 1)), ra_r));
      end
    end
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
